// File: rtl/rle_compressor.sv
// Binary-image run-length encoder.
// Pixels stream in one per accepted cycle. Runs alternate starting with a 0-run.
// Each run length goes into a small first-word-fall-through FIFO.
// A run longer than the run field can hold is split into a maximum-length run
// followed by a zero-length run of the opposite colour.
module rle_compressor #(
  parameter int unsigned RUN_W      = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pixelIn,
  input  logic             pixelValid,
  output logic             inReady,
  input  logic             imageStart,
  input  logic             imageEnd,
  output logic [RUN_W-1:0] runOut,
  output logic             runLast,
  output logic             runValid,
  input  logic             runReady,
  output logic             idle,
  output logic             protoErr
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = RUN_W + 1;
  localparam logic [PTR_W:0] OCC_FULL    = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] OCC_RDY_MAX = (PTR_W+1)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t           state, state_n;
  logic             cur_bit, cur_bit_n;
  logic [RUN_W-1:0] count, count_n;
  logic             proto_err_n;

  // FIFO entries are {run length, last flag}
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   occ, occ_n;

  logic             accept;
  logic             pop;
  logic [1:0]       n_push;
  logic [ENT_W-1:0] wdata0, wdata1;

  assign accept   = pixelValid & inReady;
  assign runValid = (occ != '0);
  assign pop      = runValid & runReady;
  assign runOut   = runValid ? mem[rd_ptr][ENT_W-1:1] : '0;
  assign runLast  = runValid & mem[rd_ptr][0];
  assign idle     = (state == ST_IDLE) && !runValid;

  // Next-state, run counting and FIFO push selection
  always_comb begin
    state_n     = state;
    cur_bit_n   = cur_bit;
    count_n     = count;
    proto_err_n = protoErr;
    n_push      = 2'd0;
    wdata0      = '0;
    wdata1      = '0;
    if (accept) begin
      if (imageStart) begin
        // A new image abandons any partial run; a leading 1 needs an empty 0-run first
        cur_bit_n = pixelIn;
        count_n   = RUN_W'(1);
        state_n   = ST_RUN;
        if (pixelIn) begin
          n_push = 2'd1;
          wdata0 = '0;
        end
      end else if (state == ST_IDLE) begin
        proto_err_n = 1'b1;
      end else if (pixelIn != cur_bit) begin
        n_push    = 2'd1;
        wdata0    = {count, 1'b0};
        cur_bit_n = pixelIn;
        count_n   = RUN_W'(1);
      end else if (count != '1) begin
        count_n = count + 1'b1;
      end else begin
        // Saturated run: emit max run plus an empty opposite run, keep the colour
        n_push  = 2'd2;
        wdata0  = {count, 1'b0};
        wdata1  = '0;
        count_n = RUN_W'(1);
      end
      if (imageEnd && (imageStart || state != ST_IDLE)) begin
        state_n = ST_FLUSH;
      end
    end else if (state == ST_FLUSH && (occ != OCC_FULL || pop)) begin
      n_push  = 2'd1;
      wdata0  = {count, 1'b1};
      state_n = ST_IDLE;
    end
    occ_n = occ + (PTR_W+1)'(n_push) - (PTR_W+1)'(pop);
  end

  // Control state, FIFO pointers and registered inReady
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cur_bit  <= 1'b0;
      count    <= '0;
      protoErr <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      inReady  <= 1'b0;
    end else begin
      state    <= state_n;
      cur_bit  <= cur_bit_n;
      count    <= count_n;
      protoErr <= proto_err_n;
      wr_ptr   <= wr_ptr + PTR_W'(n_push);
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occ     <= occ_n;
      // Two free slots are reserved so any accepted pixel can always push twice
      inReady <= (state_n != ST_FLUSH) && (occ_n <= OCC_RDY_MAX);
    end
  end

  // FIFO storage, up to two writes per cycle in order
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) begin
      mem[wr_ptr] <= wdata0;
    end
    if (n_push == 2'd2) begin
      mem[wr_ptr + 1'b1] <= wdata1;
    end
  end

endmodule

// File: tb/tb_rle_compressor.sv
// Self-checking bench for rle_compressor with a run-list reference model.
module tb_rle_compressor;

  localparam int unsigned RUN_W = 6;
  localparam int unsigned DEPTH = 4;
  localparam int MAXRUN = 63;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pixelIn = 1'b0;
  logic             pixelValid = 1'b0;
  logic             inReady;
  logic             imageStart = 1'b0;
  logic             imageEnd = 1'b0;
  logic [RUN_W-1:0] runOut;
  logic             runLast;
  logic             runValid;
  logic             runReady = 1'b0;
  logic             idle;
  logic             protoErr;

  int errors = 0;
  int checks = 0;
  int stalls = 0;
  int rr_mode = 1;   // 0: hold off, 1: always ready, 2: random
  int got[$];
  int exp_q[$];
  bit px[$];

  rle_compressor #(.RUN_W(RUN_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pixelIn(pixelIn), .pixelValid(pixelValid),
    .inReady(inReady), .imageStart(imageStart), .imageEnd(imageEnd),
    .runOut(runOut), .runLast(runLast), .runValid(runValid),
    .runReady(runReady), .idle(idle), .protoErr(protoErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    case (rr_mode)
      0:       runReady = 1'b0;
      1:       runReady = 1'b1;
      default: runReady = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst && runValid && runReady) got.push_back(int'(runOut) * 2 + int'(runLast));
  end

  // Reference: runs alternate from 0; long runs split as MAXRUN then empty run
  task automatic emit_run(input int len, input bit last);
    int l = len;
    while (l > MAXRUN) begin
      exp_q.push_back(MAXRUN * 2);
      exp_q.push_back(0);
      l -= MAXRUN;
    end
    exp_q.push_back(l * 2 + int'(last));
  endtask

  task automatic build_expected();
    bit cur = 1'b0;
    int len = 0;
    exp_q.delete();
    foreach (px[i]) begin
      if (px[i] != cur) begin
        emit_run(len, 1'b0);
        cur = px[i];
        len = 1;
      end else begin
        len++;
      end
    end
    emit_run(len, 1'b1);
  endtask

  task automatic send_px(input bit p, input bit s, input bit e);
    int g = 0;
    pixelIn = p; imageStart = s; imageEnd = e; pixelValid = 1'b1;
    while (!inReady && g < 500) begin
      @(posedge clk); #1;
      g++;
      stalls++;
    end
    if (!inReady) begin
      errors++; checks++;
      $display("FAIL send_px timeout: inReady=%0b required 1", inReady);
    end else begin
      @(posedge clk); #1;
    end
    pixelValid = 1'b0; imageStart = 1'b0; imageEnd = 1'b0;
  endtask

  task automatic send_image(input bit gaps);
    foreach (px[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send_px(px[i], i == 0, i == px.size() - 1);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (!idle && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL drain: idle=%0b required 1", idle);
    end
  endtask

  task automatic compare_runs(input string name);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d runs required %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s run[%0d]: got len=%0d last=%0d required len=%0d last=%0d",
                 name, i, got[i] / 2, got[i] % 2, exp_q[i] / 2, exp_q[i] % 2);
      end
    end
    got.delete();
  endtask

  task automatic run_image(input string name, input bit gaps);
    got.delete();
    build_expected();
    send_image(gaps);
    drain();
    compare_runs(name);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (runValid !== 1'b0 || runOut !== '0 || runLast !== 1'b0 || protoErr !== 1'b0 ||
        inReady !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL %s: got rv=%0b ro=%0d rl=%0b pe=%0b ir=%0b idle=%0b required 0 0 0 0 0 1",
               name, runValid, runOut, runLast, protoErr, inReady, idle);
    end
  endtask

  task automatic release_reset();
    rst = 1'b1;
    checks++;
    if (inReady !== 1'b0) begin
      errors++;
      $display("FAIL release_pre_edge inReady: got %0b required 0", inReady);
    end
    @(posedge clk); #1;
    checks++;
    if (inReady !== 1'b1 || idle !== 1'b1) begin
      errors++;
      $display("FAIL release_first_edge: got inReady=%0b idle=%0b required 1 1", inReady, idle);
    end
    got.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    check_reset_outputs("reset_held");
    release_reset();
  endtask

  task automatic test_basic();
    rr_mode = 1;
    px = '{0, 0, 0, 1, 1};
    run_image("basic_00011", 1'b0);
    px = '{1, 1, 0};
    run_image("lead_one_110", 1'b0);
    px = '{1};
    run_image("single_one", 1'b0);
    px = '{0};
    run_image("single_zero", 1'b0);
  endtask

  task automatic test_long_run();
    rr_mode = 1;
    px.delete();
    for (int i = 0; i < 70; i++) px.push_back(1'b0);
    stalls = 0;
    run_image("zeros_70", 1'b0);
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL zeros_70 stalls: got %0d required 0", stalls);
    end
    px.delete();
    px.push_back(1'b1);
    for (int i = 0; i < 127; i++) px.push_back(1'b0);
    run_image("one_then_127_zeros", 1'b0);
  endtask

  task automatic test_restart();
    rr_mode = 1;
    got.delete();
    send_px(1'b0, 1'b1, 1'b0);
    send_px(1'b0, 1'b0, 1'b0);
    send_px(1'b0, 1'b0, 1'b0);
    send_px(1'b1, 1'b1, 1'b0);
    send_px(1'b0, 1'b0, 1'b1);
    px = '{1, 0};
    build_expected();
    drain();
    compare_runs("restart_mid_image");
  endtask

  task automatic test_backpressure();
    rr_mode = 0;
    @(posedge clk); #1;
    got.delete();
    px = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    build_expected();
    send_px(1'b0, 1'b1, 1'b0);
    send_px(1'b1, 1'b0, 1'b0);
    send_px(1'b0, 1'b0, 1'b0);
    checks++;
    if (inReady !== 1'b1) begin
      errors++;
      $display("FAIL bp_two_queued inReady: got %0b required 1", inReady);
    end
    send_px(1'b1, 1'b0, 1'b0);
    checks++;
    if (inReady !== 1'b0) begin
      errors++;
      $display("FAIL bp_three_queued inReady: got %0b required 0", inReady);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (runValid !== 1'b1 || runOut !== 6'd1 || runLast !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rv=%0b ro=%0d rl=%0b required 1 1 0",
                 i, runValid, runOut, runLast);
      end
    end
    rr_mode = 1;
    for (int i = 4; i < px.size(); i++) send_px(px[i], 1'b0, i == px.size() - 1);
    drain();
    compare_runs("backpressure");
  endtask

  task automatic test_reset_midrun();
    rr_mode = 0;
    @(posedge clk); #1;
    send_px(1'b0, 1'b1, 1'b0);
    send_px(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) send_px(1'b0, 1'b0, 1'b0);
    checks++;
    if (runValid !== 1'b1 || runOut !== 6'd1) begin
      errors++;
      $display("FAIL midrun_queued: got rv=%0b ro=%0d required 1 1", runValid, runOut);
    end
    rst = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(posedge clk); #1;
    rr_mode = 1;
    release_reset();
    px = '{0, 1};
    run_image("after_reset_01", 1'b0);
  endtask

  task automatic test_proto_err();
    rr_mode = 1;
    got.delete();
    send_px(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (protoErr !== 1'b1 || runValid !== 1'b0) begin
        errors++;
        $display("FAIL proto_err[%0d]: got pe=%0b rv=%0b required 1 0", i, protoErr, runValid);
      end
      @(posedge clk); #1;
    end
    px = '{1, 0, 0, 1, 1, 1, 0};
    run_image("after_proto_err", 1'b0);
    checks++;
    if (protoErr !== 1'b1) begin
      errors++;
      $display("FAIL proto_err_sticky: got %0b required 1", protoErr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (protoErr !== 1'b0) begin
      errors++;
      $display("FAIL proto_err_reset: got %0b required 0", protoErr);
    end
    @(posedge clk); #1;
    release_reset();
  endtask

  task automatic test_random();
    rr_mode = 2;
    for (int img = 0; img < 8; img++) begin
      int total = $urandom_range(1, 160);
      bit b = 1'($urandom_range(0, 1));
      px.delete();
      while (px.size() < total) begin
        int len = ($urandom_range(0, 3) == 0) ? $urandom_range(50, 140) : $urandom_range(1, 5);
        for (int k = 0; k < len && px.size() < total; k++) px.push_back(b);
        b = ~b;
      end
      run_image($sformatf("random_img%0d", img), 1'b1);
    end
    rr_mode = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_run();
    test_restart();
    test_backpressure();
    test_reset_midrun();
    test_proto_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rle_compressor.md
RLE_COMPRESSOR -- requirements
Module: rle_compressor

Interface
REQ-001 Parameter RUN_W, default 6: run-length field width; max run = 2^RUN_W-1 (63).
REQ-002 Parameter FIFO_DEPTH, default 4: output run FIFO entries, power of two, >=4.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 pixelIn  in  1  binary pixel value.
REQ-006 pixelValid  in  1  pixelIn valid this cycle.
REQ-007 inReady  out  1  block accepts pixel; transfer = pixelValid & inReady.
REQ-008 imageStart  in  1  qualifies accepted pixel as first of image.
REQ-009 imageEnd  in  1  qualifies accepted pixel as last of image.
REQ-010 runOut  out  RUN_W  run length at FIFO head.
REQ-011 runLast  out  1  head entry is final run of image.
REQ-012 runValid  out  1  FIFO non-empty.
REQ-013 runReady  in  1  consumer pops; pop = runValid & runReady.
REQ-014 idle  out  1  FSM in IDLE and FIFO empty.
REQ-015 protoErr  out  1  sticky protocol-error flag.

Function
REQ-016 Encoding: alternating runs, first run always a 0-run; runOut = pixel count of the run, range 0..63; decoder reloads run count per entry and toggles bit.
REQ-017 FSM states IDLE, RUN, FLUSH.
REQ-018 Internal regs: curBit (1b), count (RUN_W bits, counts 1..63).
REQ-019 inReady = 1 in IDLE/RUN when FIFO free entries >= 2 (sampled at cycle start); 0 in FLUSH and while rst low.
REQ-020 Accepted pixel with imageStart (any state): current count discarded without push; pixelIn=0 -> curBit=0, count=1; pixelIn=1 -> push {0, last=0}, curBit=1, count=1; state RUN.
REQ-021 Accepted pixel in RUN, no imageStart, pixelIn != curBit: push {count, last=0}; curBit=pixelIn; count=1.
REQ-022 Accepted pixel in RUN, pixelIn == curBit, count < 63: count+1.
REQ-023 Accepted pixel in RUN, pixelIn == curBit, count == 63: push {63,0} then {0,0} same cycle (two writes, order preserved); count=1.
REQ-024 Accepted pixel with imageEnd: processed per REQ-020..023 first, then state FLUSH.
REQ-025 FLUSH: push {count, last=1} when free >= 1 (same-cycle pop counts as free), then IDLE; imageStart+imageEnd on one pixel = valid 1-pixel image.
REQ-026 Accepted pixel in IDLE without imageStart: dropped, no push, protoErr set to 1.
REQ-027 protoErr clears only on reset.
REQ-028 FIFO: first-word-fall-through, width RUN_W+1, up to 2 writes and 1 read per cycle; simultaneous push/pop legal at any occupancy; never overflows (guaranteed by REQ-019/025), no entry lost or reordered.
REQ-029 Latency: pushed entry visible on runOut/runValid the cycle after the accepting edge.
REQ-030 runOut/runLast hold stable while runValid & !runReady.

Reset
REQ-031 rst low asynchronously: FSM=IDLE, FIFO empty, curBit=0, count=0, runValid=0, runOut=0, runLast=0, protoErr=0, inReady=0, idle=1.
REQ-032 First edge after rst high: inReady=1; reset mid-run discards partial run and all FIFO contents.

Verification
REQ-033 Pixels 0,0,0,1,1 (start on 1st, end on 5th), runReady=1 -> runs 3,2; runLast only on 2.
REQ-034 Pixels 1,1,0 -> runs 0,2,1(last).
REQ-035 70 zeros -> runs 63,0,7(last); pixels 1..63 never stall inReady when runReady=1.
REQ-036 runReady=0, pixels 0,1,0,1,0,1,... -> inReady falls when FIFO holds 3; raise runReady -> 1,1,1,... popped in order, no loss, no duplicate.
REQ-037 rst low during 20-pixel run with 2 queued entries -> all outputs at REQ-031 values; next image 0,1 -> 1,1(last).
REQ-038 In IDLE, pixelValid=1 without imageStart -> no runValid, protoErr=1 until reset; following proper image encodes correctly.
